// File: rtl/trace_plotter.sv
`default_nettype none
// ============================================================================
// Module   : trace_plotter
// Purpose  : Oscilloscope drawing stage. For each ADC sample it erases one
//            screen column (with a centre grid line), then draws a vertical
//            segment joining the previous sample's row to the current one.
// Revision : 1.0 - initial release
// ============================================================================
module trace_plotter #(
    parameter int         SCREEN_W     = 320,
    parameter int         SCREEN_H     = 240,
    parameter logic [2:0] BG_COLOUR    = 3'b000,
    parameter logic [2:0] GRID_COLOUR  = 3'b001,
    parameter int         GRID_ROW     = 120,
    parameter logic [2:0] TRACE_COLOUR = 3'b010
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       frame_done
);

    localparam logic [8:0] c_X_MAX    = 9'(SCREEN_W - 1);
    localparam logic [7:0] c_Y_MAX    = 8'(SCREEN_H - 1);
    localparam logic [7:0] c_GRID_ROW = 8'(GRID_ROW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state,  w_state_nx;
    logic [8:0] r_col,    w_col_nx;
    logic [7:0] r_prev_y, w_prev_y_nx;
    logic [7:0] r_cur_y,  w_cur_y_nx;
    logic       r_first,  w_first_nx;

    logic       r_ready,  w_ready_nx;
    logic [8:0] r_x,      w_x_nx;
    logic [7:0] r_y,      w_y_nx;
    logic [2:0] r_colour, w_colour_nx;
    logic       r_plot,   w_plot_nx;
    logic       r_frame,  w_frame_nx;

    // Row mapping: 0 at the top of the screen, so large samples map to small rows.
    logic [11:0] w_prod;
    logic [7:0]  w_scaled;
    logic [7:0]  w_map_y;
    assign w_prod   = {4'b0000, sample} * 12'd15;
    assign w_scaled = 8'(w_prod >> 4);
    assign w_map_y  = c_Y_MAX - w_scaled;

    // Segment endpoints; a column following a wrap or reset has no predecessor.
    logic [7:0] w_ylo;
    logic [7:0] w_yhi;
    always_comb begin
        w_ylo = r_cur_y;
        w_yhi = r_cur_y;
        if (!r_first) begin
            if (r_prev_y < r_cur_y) begin
                w_ylo = r_prev_y;
            end else begin
                w_yhi = r_prev_y;
            end
        end
    end

    logic [7:0] w_erase_y_nx;
    assign w_erase_y_nx = r_y + 8'd1;

    always_comb begin
        w_state_nx  = r_state;
        w_col_nx    = r_col;
        w_prev_y_nx = r_prev_y;
        w_cur_y_nx  = r_cur_y;
        w_first_nx  = r_first;
        w_ready_nx  = r_ready;
        w_x_nx      = r_x;
        w_y_nx      = r_y;
        w_colour_nx = r_colour;
        w_plot_nx   = 1'b0;
        w_frame_nx  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready_nx = 1'b1;
                if (sample_valid && r_ready) begin
                    w_cur_y_nx  = w_map_y;
                    w_ready_nx  = 1'b0;
                    w_state_nx  = S_ERASE;
                    w_x_nx      = r_col;
                    w_y_nx      = 8'd0;
                    w_colour_nx = (c_GRID_ROW == 8'd0) ? GRID_COLOUR : BG_COLOUR;
                    w_plot_nx   = 1'b1;
                end
            end

            S_ERASE: begin
                w_plot_nx = 1'b1;
                if (r_y == c_Y_MAX) begin
                    w_state_nx  = S_DRAW;
                    w_y_nx      = w_ylo;
                    w_colour_nx = TRACE_COLOUR;
                end else begin
                    w_y_nx      = w_erase_y_nx;
                    w_colour_nx = (w_erase_y_nx == c_GRID_ROW) ? GRID_COLOUR : BG_COLOUR;
                end
            end

            S_DRAW: begin
                if (r_y == w_yhi) begin
                    w_state_nx = S_DONE;
                    w_frame_nx = (r_col == c_X_MAX);
                end else begin
                    w_plot_nx = 1'b1;
                    w_y_nx    = r_y + 8'd1;
                end
            end

            S_DONE: begin
                w_ready_nx  = 1'b1;
                w_prev_y_nx = r_cur_y;
                w_state_nx  = S_IDLE;
                if (r_col == c_X_MAX) begin
                    w_col_nx   = 9'd0;
                    w_first_nx = 1'b1;
                end else begin
                    w_col_nx   = r_col + 9'd1;
                    w_first_nx = 1'b0;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_col    <= 9'd0;
            r_prev_y <= 8'd0;
            r_cur_y  <= 8'd0;
            r_first  <= 1'b1;
            r_ready  <= 1'b1;
            r_x      <= 9'd0;
            r_y      <= 8'd0;
            r_colour <= 3'b000;
            r_plot   <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_col    <= w_col_nx;
            r_prev_y <= w_prev_y_nx;
            r_cur_y  <= w_cur_y_nx;
            r_first  <= w_first_nx;
            r_ready  <= w_ready_nx;
            r_x      <= w_x_nx;
            r_y      <= w_y_nx;
            r_colour <= w_colour_nx;
            r_plot   <= w_plot_nx;
            r_frame  <= w_frame_nx;
        end
    end

    assign sample_ready = r_ready;
    assign x            = r_x;
    assign y            = r_y;
    assign colour       = r_colour;
    assign plot         = r_plot;
    assign frame_done   = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_trace_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_plotter
// Purpose  : Directed self-checking bench for trace_plotter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_plotter;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] sample;
    logic       sample_valid;
    logic       sample_ready;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       frame_done;

    always #5 clock = ~clock;

    trace_plotter u_dut (
        .clock        (clock),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .frame_done   (frame_done)
    );

    int errors = 0;
    int checks = 0;

    // Per-column observations
    int col_nplot;
    int col_bad;
    int col_gap;
    int col_rdy_low;
    int col_fd;
    int col_timeout;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Feeds one sample and watches the whole column; junk valid pulses are
    // driven while the block is busy and must be ignored.
    task automatic run_column(input logic [7:0] s, input int col, input int ylo, input int yhi);
        int  k;
        int  cyc;
        bit  seen_off;
        col_nplot   = 0;
        col_bad     = 0;
        col_gap     = 0;
        col_rdy_low = 0;
        col_fd      = 0;
        col_timeout = 0;
        cyc = 0;
        while (!sample_ready && cyc < 1000) begin
            @(negedge clock);
            cyc++;
        end
        if (!sample_ready) col_timeout++;
        sample       = s;
        sample_valid = 1'b1;
        @(posedge clock);
        #1;
        sample = 8'hAA;
        k        = 0;
        seen_off = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clock);
            if (sample_ready) break;
            sample_valid = i[0];
            col_rdy_low++;
            if (frame_done) col_fd++;
            if (plot) begin
                if (seen_off) col_gap++;
                if (int'(x) != col) col_bad++;
                if (k < 240) begin
                    if (int'(y) != k) col_bad++;
                    if (colour != ((k == 120) ? 3'b001 : 3'b000)) col_bad++;
                end else begin
                    if (int'(y) != ylo + (k - 240)) col_bad++;
                    if (int'(y) > yhi) col_bad++;
                    if (colour != 3'b010) col_bad++;
                end
                k++;
            end else begin
                seen_off = 1'b1;
            end
        end
        sample_valid = 1'b0;
        if (!sample_ready) col_timeout++;
        col_nplot = k;
    endtask

    task automatic verify_column(input string tag, input int n, input int fd_exp);
        check({tag, " plot_cycles"}, col_nplot, 240 + n);
        check({tag, " writes_bad"}, col_bad, 0);
        check({tag, " plot_gap"}, col_gap, 0);
        check({tag, " ready_low"}, col_rdy_low, 241 + n);
        check({tag, " frame_done"}, col_fd, fd_exp);
        check({tag, " timeout"}, col_timeout, 0);
    endtask

    int fd_total;
    int fd_col;
    int wrap_bad;
    int cyc;

    initial begin
        reset        = 1'b1;
        sample       = 8'd0;
        sample_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst ready", int'(sample_ready), 1);
        check("rst plot", int'(plot), 0);
        check("rst x", int'(x), 0);
        check("rst y", int'(y), 0);
        check("rst colour", int'(colour), 0);
        check("rst frame_done", int'(frame_done), 0);

        // 255 -> row 0, first column after reset: single pixel
        run_column(8'd255, 0, 0, 0);
        verify_column("col0", 1, 0);
        // 0 -> row 239: segment 0..239
        run_column(8'd0, 1, 0, 239);
        verify_column("col1", 240, 0);
        // 255 -> row 0 after row 239: segment 0..239
        run_column(8'd255, 2, 0, 239);
        verify_column("col2", 240, 0);
        // 128 -> row 119 after row 0
        run_column(8'd128, 3, 0, 119);
        verify_column("col3", 120, 0);
        // 64 -> row 179 after row 119: 61 writes
        run_column(8'd64, 4, 119, 179);
        verify_column("col4", 61, 0);

        // Reset while erasing column 5, at row 50
        sample       = 8'd100;
        sample_valid = 1'b1;
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!(plot && y == 8'd50) && cyc < 400);
        check("mid_erase reached", int'(plot && y == 8'd50), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst plot", int'(plot), 0);
        check("mid_rst ready", int'(sample_ready), 1);
        check("mid_rst x", int'(x), 0);
        @(negedge clock);
        reset = 1'b0;
        run_column(8'd128, 0, 119, 119);
        verify_column("post_rst", 1, 0);

        // Rest of the frame at constant level; frame_done only after column 319
        fd_total = 0;
        fd_col   = -1;
        wrap_bad = 0;
        for (int c = 1; c < 320; c++) begin
            run_column(8'd128, c, 119, 119);
            if (col_fd != 0) begin
                fd_total += col_fd;
                fd_col = c;
            end
            if (col_nplot != 241 || col_bad != 0 || col_gap != 0 ||
                col_rdy_low != 242 || col_timeout != 0) wrap_bad++;
        end
        check("frame columns_bad", wrap_bad, 0);
        check("frame_done count", fd_total, 1);
        check("frame_done column", fd_col, 319);

        // After wrap the segment must not join row 119 to row 0
        run_column(8'd255, 0, 0, 0);
        verify_column("wrap", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trace_plotter.md
Name: trace_plotter

Overview:
- Upstream drawing stage for the oscilloscope display. Accepts one 8-bit ADC sample per screen column and writes the video memory write port, which the VGA controller reads.
- For each column, it first erases the column to background, with a grid line. It then draws a vertical segment joining the previous sample's row to the current sample's row, producing a continuous trace.
- Columns advance 0..319 and wrap, giving a 320x240 rolling display.

Parameters:
- SCREEN_W, 320, columns per frame (x range 0..SCREEN_W-1).
- SCREEN_H, 240, rows (y range 0..SCREEN_H-1).
- BG_COLOUR, 3'b000, erase colour.
- GRID_COLOUR, 3'b001, colour of the horizontal centre line.
- GRID_ROW, 120, row painted GRID_COLOUR during erase.
- TRACE_COLOUR, 3'b010, trace colour.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- sample  in  8  unsigned ADC sample; 0 = bottom of screen.
- sample_valid  in  1  sample is present.
- sample_ready  out  1  block can accept a sample.
- x  out  9  video memory write column.
- y  out  8  video memory write row.
- colour  out  3  write colour.
- plot  out  1  write enable; memory writes (x, y, colour) on each cycle plot=1.
- frame_done  out  1  one-cycle pulse when column SCREEN_W-1 completes.

Behaviour:
- Reset values: sample_ready=1, x=0, y=0, colour=0, plot=0, frame_done=0. Internal state: state=IDLE, col=0, prev_y=0, first=1.
- Reset takes priority over everything, including mid-ERASE or mid-DRAW. The partially written column is left as is.
- Row mapping: cur_y = 239 - ((sample*15)>>4).
  - Intermediate product is 12 bits.
  - sample 255 -> 0; sample 128 -> 119; sample 0 -> 239.
- All outputs are registered.
- IDLE:
  - sample_ready=1, plot=0.
  - A handshake occurs on an edge with sample_valid=1 and sample_ready=1.
  - At that edge: latch cur_y, sample_ready<=0, state<=ERASE.
  - First erase write is presented in the same edge: x=col, y=0, plot=1.
  - sample_valid is ignored while sample_ready=0; no queueing.
- ERASE:
  - Outputs one write per cycle, rows 0..239 in order, x=col.
  - colour=GRID_COLOUR when y==GRID_ROW, otherwise BG_COLOUR.
  - After the row-239 output, the next edge enters DRAW.
- DRAW:
  - ylo = min(prev_y, cur_y), yhi = max(prev_y, cur_y).
  - If first=1, then ylo = yhi = cur_y.
  - Outputs rows ylo..yhi ascending, colour=TRACE_COLOUR, x=col.
  - Segment length is n = yhi-ylo+1, from 1 to 240 cycles.
  - After the yhi output, the next edge enters DONE.
- DONE (single cycle):
  - plot=0, sample_ready<=1, prev_y<=cur_y, first<=0.
  - If col==SCREEN_W-1: col<=0, first<=1 (no segment across the wrap), frame_done=1 for this cycle.
  - Otherwise col<=col+1.
  - Then return to IDLE. A sample may be accepted on the edge after DONE.
- Timing: with acceptance at edge T, plot=1 for exactly 240+n consecutive cycles starting at T. sample_ready is 0 for 241+n cycles.
- With sample_valid held high, throughput is one column per 242+n cycles.
- x and y never exceed 319/239. plot is never asserted in IDLE or DONE.

Test Plan:
- Reset → outputs: assert reset for 2 cycles → sample_ready=1, plot=0, x=0, y=0, frame_done=0.
- First column: first sample=255 → 240 erase writes at x=0 with y=0..239; colour=3'b001 only at y=120. Then one trace write (0,0,3'b010), then ready high. Total plot cycles = 241.
- Segment draw: samples 0 then 255 → column 1 erases, then draws y=0..239 in TRACE_COLOUR (240 writes). prev_y becomes 0.
- Descending segment: samples 128 then 64 (y=119 then y=179) → column draws y=119..179 ascending, 61 writes.
- Wrap: feed 320 samples of 128 → frame_done pulses once, after the column-319 write. The next sample writes at x=0 with a single trace pixel at y=119.
- Reset mid-ERASE: assert reset at erase row 50 of column 5 → plot=0 on the next cycle, sample_ready=1, and the next accepted sample draws at x=0 with a single pixel. Valid samples pulsed while busy are ignored, and the column count is unchanged.
